// File: rtl/scheduler_acc_select.sv
// Accelerator scheduler: picks an accelerator instance per type, round-robin.
// Ports: req_* (type in), rsp_* (acc id/err out), cfg_* (info write), mem_a/mem_b (info memory).
module scheduler_acc_select #(
    parameter int MAX_ACC_TYPES = 16,
    parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ACC_TYPE_BITS-1:0] req_type,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_acc_id,
    output logic                     rsp_err,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ACC_TYPE_BITS-1:0] cfg_type,
    input  logic [47:0]              cfg_data,
    output logic [ACC_TYPE_BITS-1:0] mem_a_addr,
    output logic                     mem_a_en,
    output logic [47:0]              mem_a_din,
    output logic [ACC_TYPE_BITS-1:0] mem_b_addr,
    output logic                     mem_b_en,
    input  logic [47:0]              mem_b_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state;
    logic [ACC_TYPE_BITS-1:0] curType;
    logic [7:0]               rrPtr [MAX_ACC_TYPES];
    logic [7:0]               nextPtr;

    logic       cfgFire;
    logic       reqFire;
    logic [7:0] infoFirst;
    logic [7:0] infoCount;
    logic [7:0] curPtr;
    logic [7:0] idx;
    logic [8:0] idxInc;
    logic [7:0] wrapPtr;
    logic       unusedInfo;

    // Config writes win over requests while idle.
    assign cfg_ready = (state == IDLE);
    assign req_ready = (state == IDLE) && !cfg_valid;
    assign cfgFire   = cfg_valid && cfg_ready;
    assign reqFire   = req_valid && req_ready;

    assign mem_a_en   = cfgFire;
    assign mem_a_addr = cfg_type;
    assign mem_a_din  = cfg_data;
    assign mem_b_en   = reqFire;
    assign mem_b_addr = req_type;

    assign infoFirst  = mem_b_dout[7:0];
    assign infoCount  = mem_b_dout[15:8];
    assign unusedInfo = ^mem_b_dout[47:16];

    // A stale pointer (count shrank) restarts the rotation at instance 0.
    assign curPtr  = rrPtr[curType];
    assign idx     = (curPtr < infoCount) ? curPtr : 8'd0;
    assign idxInc  = {1'b0, idx} + 9'd1;
    assign wrapPtr = (idxInc == {1'b0, infoCount}) ? 8'd0 : idxInc[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            curType    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_acc_id <= 8'd0;
            nextPtr    <= 8'd0;
            for (int i = 0; i < MAX_ACC_TYPES; i++) begin
                rrPtr[i] <= 8'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfgFire) begin
                        rrPtr[cfg_type] <= 8'd0;
                    end else if (reqFire) begin
                        curType <= req_type;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    if (infoCount == 8'd0) begin
                        rsp_acc_id <= 8'd0;
                        rsp_err    <= 1'b1;
                        nextPtr    <= curPtr;
                    end else begin
                        rsp_acc_id <= infoFirst + idx;
                        rsp_err    <= 1'b0;
                        nextPtr    <= wrapPtr;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        // Pointer only moves once the consumer takes the id.
                        if (!rsp_err) begin
                            rrPtr[curType] <= nextPtr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scheduler_acc_select.sv
// Testbench for scheduler_acc_select: directed table, corner sequences, random ops.
// Holds a registered-read info memory and a per-type round-robin model.
module tb_scheduler_acc_select;

    localparam int NT = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [TW-1:0] req_type;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_acc_id;
    logic          rsp_err;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [TW-1:0] cfg_type;
    logic [47:0]   cfg_data;
    logic [TW-1:0] mem_a_addr;
    logic          mem_a_en;
    logic [47:0]   mem_a_din;
    logic [TW-1:0] mem_b_addr;
    logic          mem_b_en;
    logic [47:0]   mem_b_dout;

    logic [47:0] mem [NT];

    int vectors = 0;
    int miscompares = 0;

    int mFirst [NT];
    int mCount [NT];
    int mPtr [NT];

    typedef struct {
        bit         isCfg;
        int         typ;
        int         first;
        int         count;
        logic [7:0] expId;
        logic       expErr;
    } vec_t;

    vec_t tbl[$];

    scheduler_acc_select #(.MAX_ACC_TYPES(NT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_acc_id(rsp_acc_id), .rsp_err(rsp_err),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_type(cfg_type), .cfg_data(cfg_data),
        .mem_a_addr(mem_a_addr), .mem_a_en(mem_a_en), .mem_a_din(mem_a_din),
        .mem_b_addr(mem_b_addr), .mem_b_en(mem_b_en), .mem_b_dout(mem_b_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_a_en) mem[mem_a_addr] <= mem_a_din;
        if (mem_b_en) mem_b_dout <= mem[mem_b_addr];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelExpect(input int t, output logic [7:0] id,
                               output logic err);
        int i;
        if (mCount[t] == 0) begin
            id = 8'd0;
            err = 1'b1;
        end else begin
            i = (mPtr[t] < mCount[t]) ? mPtr[t] : 0;
            id = 8'((mFirst[t] + i) % 256);
            err = 1'b0;
        end
    endtask

    task automatic modelCommit(input int t);
        int i;
        if (mCount[t] != 0) begin
            i = (mPtr[t] < mCount[t]) ? mPtr[t] : 0;
            mPtr[t] = (i + 1) % mCount[t];
        end
    endtask

    task automatic modelCfg(input int t, input int first, input int count);
        mFirst[t] = first;
        mCount[t] = count;
        mPtr[t] = 0;
    endtask

    // Called #1 after an edge with the DUT idle.
    task automatic cfgWrite(input int t, input int first, input int count);
        cfg_valid = 1'b1;
        cfg_type = TW'(t);
        cfg_data = {32'($urandom), 8'(count), 8'(first)};
        #1;
        chk("cfg_mem_a_en", 64'(mem_a_en), 64'(1));
        chk("cfg_mem_a_addr", 64'(mem_a_addr), 64'(t));
        chk("cfg_mem_a_din", 64'(mem_a_din), 64'(cfg_data));
        chk("cfg_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        modelCfg(t, first, count);
    endtask

    task automatic issue(input int t, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1;
        req_type = TW'(t);
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (req_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            chk("req_ready_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
        end else begin
            chk("acc_mem_b_en", 64'(mem_b_en), 64'(1));
            chk("acc_mem_b_addr", 64'(mem_b_addr), 64'(t));
            chk("acc_mem_a_en", 64'(mem_a_en), 64'(0));
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    // Entered #1 after the accepting edge N.
    task automatic collect(input int t, input int hold, input logic [7:0] eId,
                           input logic eErr, input string name);
        chk({name, "_lat_n1"}, 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;
        chk({name, "_lat_n2"}, 64'(rsp_valid), 64'(1));
        for (int i = 0; i < hold; i++) begin
            chk({name, "_hold_valid"}, 64'(rsp_valid), 64'(1));
            chk({name, "_hold_id"}, 64'(rsp_acc_id), 64'(eId));
            chk({name, "_hold_rdy"}, 64'(req_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        chk({name, "_id"}, 64'(rsp_acc_id), 64'(eId));
        chk({name, "_err"}, 64'(rsp_err), 64'(eErr));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, "_done_valid"}, 64'(rsp_valid), 64'(0));
        chk({name, "_done_rdy"}, 64'(req_ready), 64'(1));
        modelCommit(t);
    endtask

    task automatic runModel(input int t, input int hold, input string name);
        logic [7:0] eId;
        logic eErr;
        bit ok;
        modelExpect(t, eId, eErr);
        issue(t, ok);
        if (ok) collect(t, hold, eId, eErr, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [7:0] eId;
        logic eErr;

        tbl.push_back('{1'b1, 3, 8'h10, 3, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 3, 0, 0, 8'h10, 1'b0});
        tbl.push_back('{1'b0, 3, 0, 0, 8'h11, 1'b0});
        tbl.push_back('{1'b0, 3, 0, 0, 8'h12, 1'b0});
        tbl.push_back('{1'b0, 3, 0, 0, 8'h10, 1'b0});
        tbl.push_back('{1'b1, 5, 8'h40, 0, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 5, 0, 0, 8'h00, 1'b1});
        tbl.push_back('{1'b1, 5, 8'h40, 2, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 5, 0, 0, 8'h40, 1'b0});
        tbl.push_back('{1'b0, 5, 0, 0, 8'h41, 1'b0});
        tbl.push_back('{1'b1, 7, 8'hFE, 4, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 7, 0, 0, 8'hFE, 1'b0});
        tbl.push_back('{1'b0, 7, 0, 0, 8'hFF, 1'b0});
        tbl.push_back('{1'b0, 7, 0, 0, 8'h00, 1'b0});
        tbl.push_back('{1'b0, 7, 0, 0, 8'h01, 1'b0});
        tbl.push_back('{1'b0, 7, 0, 0, 8'hFE, 1'b0});

        for (int i = 0; i < NT; i++) modelCfg(i, 0, 0);

        rst = 1'b1;
        req_valid = 1'b0;
        req_type = '0;
        rsp_ready = 1'b0;
        cfg_valid = 1'b0;
        cfg_type = '0;
        cfg_data = '0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_id", 64'(rsp_acc_id), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_cfg_ready", 64'(cfg_ready), 64'(1));
        chk("rst_mem_a_en", 64'(mem_a_en), 64'(0));
        chk("rst_mem_b_en", 64'(mem_b_en), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: rotation, zero-count error, reconfig, mod-256 wrap.
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].isCfg) begin
                cfgWrite(tbl[i].typ, tbl[i].first, tbl[i].count);
            end else begin
                issue(tbl[i].typ, ok);
                if (ok) collect(tbl[i].typ, 0, tbl[i].expId, tbl[i].expErr,
                                $sformatf("tbl%0d", i));
            end
        end

        // Back-pressure for 5 cycles, then confirm the pointer moved once.
        issue(3, ok);
        if (ok) collect(3, 5, 8'h11, 1'b0, "bp");
        issue(3, ok);
        if (ok) collect(3, 0, 8'h12, 1'b0, "bp_next");

        // Config and request together: config first, request next cycle.
        cfg_valid = 1'b1;
        cfg_type = TW'(9);
        cfg_data = {32'hDEADBEEF, 8'd2, 8'h20};
        req_valid = 1'b1;
        req_type = TW'(9);
        #1;
        chk("both_mem_a_en", 64'(mem_a_en), 64'(1));
        chk("both_mem_b_en", 64'(mem_b_en), 64'(0));
        chk("both_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        modelCfg(9, 8'h20, 2);
        #1;
        chk("both_req_ready2", 64'(req_ready), 64'(1));
        chk("both_mem_b_en2", 64'(mem_b_en), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        collect(9, 0, 8'h20, 1'b0, "both");

        // Reset while a response is pending.
        issue(3, ok);
        if (ok) collect(3, 0, 8'h10, 1'b0, "pre_rst");
        issue(3, ok);
        @(posedge clk);
        #1;
        chk("rst_resp_valid_before", 64'(rsp_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(rsp_valid), 64'(0));
        chk("rst_async_id", 64'(rsp_acc_id), 64'(0));
        chk("rst_async_rdy", 64'(req_ready), 64'(1));
        for (int i = 0; i < NT; i++) mPtr[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(3, ok);
        if (ok) collect(3, 0, 8'h10, 1'b0, "post_rst");

        // Random traffic against the model.
        for (int i = 0; i < NT; i++) begin
            cfgWrite(i, $urandom_range(0, 255), $urandom_range(0, 5));
        end
        for (int n = 0; n < 80; n++) begin
            int t;
            t = $urandom_range(0, NT - 1);
            if ($urandom_range(0, 4) == 0) begin
                cfgWrite(t, $urandom_range(0, 255),
                         ($urandom_range(0, 7) == 0) ? 200 : $urandom_range(0, 5));
            end else begin
                modelExpect(t, eId, eErr);
                issue(t, ok);
                if (ok) collect(t, $urandom_range(0, 2), eId, eErr,
                                $sformatf("rnd%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
